// File: rtl/cacheline_adapter_if.sv
// Bundle of cache-side (dfp_*) and burst-memory-side (bmem_*) signals for the
// cache line adapter.
//   slave  : the adapter's view (takes cache requests and memory beats,
//            drives line data, responses and memory commands).
//   master : the environment's view (cache plus burst memory), i.e. the
//            mirror image of slave.
interface cacheline_adapter_if;
    // Cache side
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    // Burst memory side
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  bmem_ready, bmem_rdata, bmem_rvalid,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output bmem_ready, bmem_rdata, bmem_rvalid,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/cacheline_adapter.sv
// Cache line adapter: converts 256-bit cache line reads/writes into 4-beat
// 64-bit burst memory transactions.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - cacheline_adapter_if.slave: dfp_* cache request/response side and
//          bmem_* burst memory command/data side
// A read issues a one-cycle bmem_read and collects 4 beats (possibly with gaps)
// into dfp_rdata; a write streams 4 consecutive beats, the first in the
// acceptance cycle itself. Each request ends with a one-cycle dfp_resp.
module cacheline_adapter (
    input logic               clk,
    input logic               rst,
    cacheline_adapter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrBurst, StResp} state_e;

    state_e        state_q, state_d;
    logic [1:0]    count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic [255:0]  wdata_q, wdata_d;
    logic [255:0]  rdata_q, rdata_d;

    logic [31:0]   line_addr;
    logic [31:0]   addr_out;
    logic [63:0]   wdata_out;
    logic          cmd_read;
    logic          cmd_write;
    logic          resp;

    // Masking (rather than slicing) keeps every address bit in use.
    assign line_addr = bus.dfp_addr & 32'hffff_ffe0;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cmd_read  = 1'b0;
        cmd_write = 1'b0;
        resp      = 1'b0;
        // After acceptance the burst runs from latched copies only.
        addr_out  = addr_q;
        wdata_out = wdata_q[{count_q, 6'd0} +: 64];

        case (state_q)
            StIdle: begin
                addr_out  = line_addr;
                wdata_out = bus.dfp_wdata[63:0];
                if (bus.dfp_read && bus.bmem_ready) begin
                    // Read wins when both requests are present.
                    cmd_read = 1'b1;
                    addr_d   = line_addr;
                    count_d  = 2'd0;
                    state_d  = StRdWait;
                end else if (bus.dfp_write && bus.bmem_ready) begin
                    // Beat 0 goes out now, beats 1..3 from the latched line.
                    cmd_write = 1'b1;
                    addr_d    = line_addr;
                    wdata_d   = bus.dfp_wdata;
                    count_d   = 2'd1;
                    state_d   = StWrBurst;
                end
            end
            StWrBurst: begin
                cmd_write = 1'b1;
                count_d   = count_q + 2'd1;
                if (count_q == 2'd3) begin
                    state_d = StResp;
                end
            end
            StRdWait: begin
                if (bus.bmem_rvalid) begin
                    rdata_d[{count_q, 6'd0} +: 64] = bus.bmem_rdata;
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd3) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                resp    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 256'd0;
            rdata_q <= 256'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Commands and responses are suppressed combinationally while rst is high,
    // so nothing leaks out even in the cycle reset is first asserted.
    assign bus.bmem_read  = cmd_read & ~rst;
    assign bus.bmem_write = cmd_write & ~rst;
    assign bus.dfp_resp   = resp & ~rst;
    assign bus.bmem_addr  = addr_out;
    assign bus.bmem_wdata = wdata_out;
    assign bus.dfp_rdata  = rdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized self-checking bench for cacheline_adapter. Each transaction is
// driven cycle by cycle; expected command, address, beat and response timing
// come from the transaction description, and the expected read line is kept as
// a plain 256-bit value updated beat by beat.
module tb_cacheline_adapter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adapter_if bus ();

    cacheline_adapter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [255:0] exp_rdata;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Random read beat traffic that the adapter must ignore.
    task automatic noise();
        bus.bmem_rvalid = 1'($urandom_range(0, 1));
        bus.bmem_rdata  = {$urandom, $urandom};
    endtask

    // No command, no response, line data unchanged.
    task automatic quiet(input string tag);
        check({tag, "_rd"}, 256'(bus.bmem_read), 256'd0);
        check({tag, "_wr"}, 256'(bus.bmem_write), 256'd0);
        check({tag, "_resp"}, 256'(bus.dfp_resp), 256'd0);
        check({tag, "_rdata"}, bus.dfp_rdata, exp_rdata);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.dfp_read   = 1'b0;
            bus.dfp_write  = 1'b0;
            bus.bmem_ready = 1'($urandom_range(0, 1));
            noise();
            #1;
            quiet("idle");
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input bit both, input int stall,
                           input logic [255:0] line);
        logic [31:0] line_addr;
        int gap;
        line_addr = {addr[31:5], 5'd0};
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            bus.dfp_read   = 1'b1;
            bus.dfp_write  = both;
            bus.dfp_addr   = addr;
            bus.dfp_wdata  = rand256();
            bus.bmem_ready = 1'b0;
            noise();
            #1;
            quiet("rd_stall");
        end
        @(negedge clk);
        bus.dfp_read    = 1'b1;
        bus.dfp_write   = both;
        bus.dfp_addr    = addr;
        bus.dfp_wdata   = rand256();
        bus.bmem_ready  = 1'b1;
        bus.bmem_rvalid = 1'b0;
        #1;
        check("rd_cmd", 256'(bus.bmem_read), 256'd1);
        check("rd_cmd_nowr", 256'(bus.bmem_write), 256'd0);
        check("rd_cmd_addr", 256'(bus.bmem_addr), 256'(line_addr));
        check("rd_cmd_resp", 256'(bus.dfp_resp), 256'd0);
        check("rd_cmd_rdata", bus.dfp_rdata, exp_rdata);
        for (int i = 0; i < 4; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.dfp_addr    = $urandom;
                bus.dfp_wdata   = rand256();
                bus.bmem_ready  = 1'($urandom_range(0, 1));
                bus.bmem_rvalid = 1'b0;
                bus.bmem_rdata  = {$urandom, $urandom};
                #1;
                quiet("rd_gap");
                check("rd_gap_addr", 256'(bus.bmem_addr), 256'(line_addr));
            end
            @(negedge clk);
            bus.dfp_addr    = $urandom;
            bus.bmem_ready  = 1'($urandom_range(0, 1));
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = line[64*i +: 64];
            #1;
            quiet("rd_beat");
            check("rd_beat_addr", 256'(bus.bmem_addr), 256'(line_addr));
            exp_rdata[64*i +: 64] = line[64*i +: 64];
        end
        @(negedge clk);
        bus.bmem_rvalid = 1'b0;
        #1;
        check("rd_resp", 256'(bus.dfp_resp), 256'd1);
        check("rd_resp_rd", 256'(bus.bmem_read), 256'd0);
        check("rd_resp_wr", 256'(bus.bmem_write), 256'd0);
        check("rd_line", bus.dfp_rdata, line);
    endtask

    task automatic do_write(input logic [31:0] addr, input int stall, input logic [255:0] data);
        logic [31:0] line_addr;
        line_addr = {addr[31:5], 5'd0};
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            bus.dfp_read   = 1'b0;
            bus.dfp_write  = 1'b1;
            bus.dfp_addr   = addr;
            bus.dfp_wdata  = data;
            bus.bmem_ready = 1'b0;
            noise();
            #1;
            quiet("wr_stall");
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            if (b == 0) begin
                bus.dfp_read   = 1'b0;
                bus.dfp_write  = 1'b1;
                bus.dfp_addr   = addr;
                bus.dfp_wdata  = data;
                bus.bmem_ready = 1'b1;
            end else begin
                bus.dfp_addr   = $urandom;
                bus.dfp_wdata  = rand256();
                bus.bmem_ready = 1'($urandom_range(0, 1));
            end
            noise();
            #1;
            check("wr_beat_wr", 256'(bus.bmem_write), 256'd1);
            check("wr_beat_rd", 256'(bus.bmem_read), 256'd0);
            check("wr_beat_data", 256'(bus.bmem_wdata), 256'(data[64*b +: 64]));
            check("wr_beat_addr", 256'(bus.bmem_addr), 256'(line_addr));
            check("wr_beat_resp", 256'(bus.dfp_resp), 256'd0);
            check("wr_beat_rdata", bus.dfp_rdata, exp_rdata);
        end
        @(negedge clk);
        noise();
        #1;
        check("wr_resp", 256'(bus.dfp_resp), 256'd1);
        check("wr_resp_wr", 256'(bus.bmem_write), 256'd0);
        check("wr_resp_rd", 256'(bus.bmem_read), 256'd0);
        check("wr_resp_rdata", bus.dfp_rdata, exp_rdata);
    endtask

    // Read accepted, two beats delivered, then reset abandons the burst.
    task automatic reset_mid_read(input logic [31:0] addr);
        @(negedge clk);
        bus.dfp_read    = 1'b1;
        bus.dfp_write   = 1'b0;
        bus.dfp_addr    = addr;
        bus.bmem_ready  = 1'b1;
        bus.bmem_rvalid = 1'b0;
        #1;
        check("rst_cmd", 256'(bus.bmem_read), 256'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = {$urandom, $urandom};
            #1;
            quiet("rst_beat");
            exp_rdata[64*i +: 64] = bus.bmem_rdata;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst             = 1'b1;
            bus.dfp_read    = 1'b1;
            bus.bmem_ready  = 1'b1;
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = {$urandom, $urandom};
            #1;
            check("rst_hold_rd", 256'(bus.bmem_read), 256'd0);
            check("rst_hold_wr", 256'(bus.bmem_write), 256'd0);
            check("rst_hold_resp", 256'(bus.dfp_resp), 256'd0);
            if (c == 1) check("rst_hold_rdata", bus.dfp_rdata, 256'd0);
        end
        exp_rdata = 256'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst             = 1'b0;
            bus.dfp_read    = 1'b0;
            bus.bmem_rvalid = 1'b1;
            bus.bmem_rdata  = {$urandom, $urandom};
            #1;
            quiet("rst_late");
        end
    endtask

    initial begin
        int op;
        rst             = 1'b1;
        bus.dfp_addr    = 32'd0;
        bus.dfp_read    = 1'b1;
        bus.dfp_write   = 1'b1;
        bus.dfp_wdata   = 256'd0;
        bus.bmem_ready  = 1'b1;
        bus.bmem_rdata  = 64'd0;
        bus.bmem_rvalid = 1'b1;
        exp_rdata       = 256'd0;

        @(negedge clk);
        #1;
        quiet("reset");
        @(negedge clk);
        rst             = 1'b0;
        bus.dfp_read    = 1'b0;
        bus.dfp_write   = 1'b0;
        bus.bmem_rvalid = 1'b0;
        #1;
        quiet("post_reset");

        // Directed read of the worked example
        do_read(32'h0000_1234, 1'b0, 0, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        idle(2);
        do_write(32'h0000_1234, 0, rand256());
        idle(1);
        do_read($urandom, 1'b0, 5, rand256());   // back-pressure
        idle(1);
        do_read($urandom, 1'b1, 0, rand256());   // read wins over write
        do_write($urandom, 0, rand256());        // writeback ...
        do_read($urandom, 1'b0, 0, rand256());   // ... then allocate right after resp
        idle(1);
        reset_mid_read($urandom);
        do_read($urandom, 1'b0, 0, rand256());
        idle(1);

        for (int t = 0; t < 30; t++) begin
            op = $urandom_range(0, 2);
            if (op == 0) do_read($urandom, 1'b0, $urandom_range(0, 3), rand256());
            else if (op == 1) do_read($urandom, 1'b1, $urandom_range(0, 3), rand256());
            else do_write($urandom, $urandom_range(0, 3), rand256());
            idle($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 The block SHALL have no parameters; line size is fixed at 256 bits, transferred as a burst of 4 x 64-bit beats.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 dfp_addr  input  32  cache-side line address; bits [4:0] ignored.
REQ-005 dfp_read  input  1  cache line read request, held high by the cache until dfp_resp.
REQ-006 dfp_write  input  1  cache line write request, held high by the cache until dfp_resp.
REQ-007 dfp_wdata  input  256  write line data; beat i is bits [64i+63:64i].
REQ-008 dfp_rdata  output  256  assembled read line data.
REQ-009 dfp_resp  output  1  one-cycle completion pulse for the current request.
REQ-010 bmem_addr  output  32  burst memory line address, {dfp_addr[31:5], 5'b0}.
REQ-011 bmem_read  output  1  one-cycle burst read command.
REQ-012 bmem_write  output  1  write beat valid; high for 4 consecutive cycles per write burst.
REQ-013 bmem_wdata  output  64  write beat data.
REQ-014 bmem_ready  input  1  memory can accept a new command; sampled only in IDLE.
REQ-015 bmem_rdata  input  64  read beat data.
REQ-016 bmem_rvalid  input  1  read beat valid; beats in address order, not necessarily consecutive.

Function
REQ-017 States SHALL be IDLE, RD_WAIT, WR_BURST and RESP.
REQ-018 IDLE: dfp_read && bmem_ready SHALL accept a read: bmem_read=1, bmem_addr driven in the same cycle, beat count cleared, next state RD_WAIT.
REQ-019 IDLE: dfp_write && !dfp_read && bmem_ready SHALL accept a write: bmem_write=1, bmem_wdata=dfp_wdata[63:0], bmem_addr driven, dfp_wdata latched, beat count set to 1, next state WR_BURST.
REQ-020 If dfp_read and dfp_write are both high in IDLE, the read SHALL take priority and the write SHALL NOT start.
REQ-021 IDLE with bmem_ready low SHALL issue no command and remain in IDLE.
REQ-022 WR_BURST SHALL drive bmem_write=1 and bmem_wdata = latched beat[count] on each of 3 consecutive cycles (beats 1..3), with bmem_addr held; after beat 3 the next state SHALL be RESP.
REQ-023 RD_WAIT SHALL write bmem_rdata into dfp_rdata bits [64*count+63:64*count] on each bmem_rvalid and increment a 2-bit count; on the 4th beat the next state SHALL be RESP.
REQ-024 bmem_rvalid outside RD_WAIT SHALL be ignored and SHALL NOT modify dfp_rdata.
REQ-025 RESP SHALL assert dfp_resp for exactly one cycle, then return to IDLE; the next request can be accepted in the following cycle.
REQ-026 Read latency: dfp_resp SHALL be asserted in the cycle after the 4th bmem_rvalid.
REQ-027 Write latency: dfp_resp SHALL be asserted 4 cycles after the acceptance cycle.
REQ-028 dfp_rdata SHALL be held stable from RESP until the first beat of the next read.
REQ-029 bmem_read SHALL be 0 outside the IDLE acceptance cycle; bmem_write SHALL be 0 outside the acceptance and WR_BURST cycles.
REQ-030 dfp_addr and dfp_wdata changes after acceptance SHALL NOT affect the burst in progress; bmem_addr SHALL come from a latched copy after acceptance.

Reset
REQ-031 When rst is high, the block SHALL enter IDLE, clear the beat count, and drive dfp_resp=0, bmem_read=0, bmem_write=0 in the following cycle; dfp_rdata SHALL reset to 0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst with no dfp_resp, and beats that arrive afterwards SHALL be ignored.
REQ-033 No command SHALL be issued in any cycle in which rst is high.

Verification
REQ-034 Read: dfp_read=1, dfp_addr=0x0000_1234, bmem_ready=1 -> bmem_read pulse with bmem_addr=0x0000_1220; beats 0x11..,0x22..,0x33..,0x44.. with gaps -> dfp_rdata={0x44..,0x33..,0x22..,0x11..} and a single dfp_resp the cycle after beat 4.
REQ-035 Write: dfp_write=1, dfp_wdata={D3,D2,D1,D0} -> bmem_write high for 4 consecutive cycles carrying D0,D1,D2,D3 at a constant address; dfp_resp at cycle T+4.
REQ-036 Back-pressure: bmem_ready=0 for 5 cycles with dfp_read=1 -> no command; command issued in the first cycle bmem_ready=1.
REQ-037 Both dfp_read and dfp_write high -> read burst only, bmem_write stays 0.
REQ-038 Writeback then allocate: write completes and dfp_read is asserted in the cycle after dfp_resp -> read accepted that cycle, with no duplicate command and no lost response.
REQ-039 rst after 2 read beats -> no dfp_resp, outputs low, late rvalid ignored, and the next read completes correctly.
